jtframe_ram_arb: RTL and testbench

- Three-requester arbiter that time-shares one synchronous RAM port among independent clients, e.g. the CPU, a DMA engine and a video fetcher.
- The RAM port is a registered-read port: q updates on the clock edge after the address is presented.
- Each client uses a req/ok handshake. The arbiter grants round-robin, registers address/data/we toward the RAM, and returns read data with a one-cycle ok pulse.

---
 rtl/jtframe_ram_arb.sv | 182 ++++++++++++++++++
 tb/tb_jtframe_ram_arb.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/jtframe_ram_arb.sv
// Round-robin arbiter sharing one registered-read RAM port among three req/ok clients.
// Define JTFRAME_RAM_ARB_FIXPRIO_EN for fixed priority req0 > req1 > req2.
module jtframe_ram_arb #(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          req2,
    input  logic          we0,
    input  logic          we1,
    input  logic          we2,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    input  logic [DW-1:0] din2,
    output logic [DW-1:0] dout0,
    output logic [DW-1:0] dout1,
    output logic [DW-1:0] dout2,
    output logic          ok0,
    output logic          ok1,
    output logic          ok2,
    output logic          busy,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_LATCH} state_t;

    state_t        r_state, w_state_nx;
    logic [1:0]    r_grant, w_grant_nx;
    logic [2:0]    r_ok, w_ok_nx;
    logic [AW-1:0] r_ram_addr, w_ram_addr_nx;
    logic [DW-1:0] r_ram_din, w_ram_din_nx;
    logic          r_ram_we, w_ram_we_nx;
    logic [DW-1:0] r_dout0, r_dout1, r_dout2;
    logic [DW-1:0] w_dout0_nx, w_dout1_nx, w_dout2_nx;
    logic [2:0]    w_req_v;
    logic [2:0]    w_pick;
    logic          w_win;
    logic [1:0]    w_win_idx;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_din;
    logic          w_sel_we;
`ifndef JTFRAME_RAM_ARB_FIXPRIO_EN
    logic [1:0]    r_last, w_last_nx;
`endif

    // Returns {win, index} for the first set bit of v in the order p0, p1, p2.
    function automatic logic [2:0] f_pick(input logic [2:0] v, input logic [1:0] p0,
                                          input logic [1:0] p1, input logic [1:0] p2);
        if (v[p0])      return {1'b1, p0};
        else if (v[p1]) return {1'b1, p1};
        else if (v[p2]) return {1'b1, p2};
        else            return 3'b000;
    endfunction

    // A client completing this cycle may not be re-granted in the same cycle.
    assign w_req_v = {req2, req1, req0} & ~r_ok;

    always_comb begin
`ifdef JTFRAME_RAM_ARB_FIXPRIO_EN
        w_pick = f_pick(w_req_v, 2'd0, 2'd1, 2'd2);
`else
        case (r_last)
            2'd0:    w_pick = f_pick(w_req_v, 2'd1, 2'd2, 2'd0);
            2'd1:    w_pick = f_pick(w_req_v, 2'd2, 2'd0, 2'd1);
            default: w_pick = f_pick(w_req_v, 2'd0, 2'd1, 2'd2);
        endcase
`endif
    end

    assign w_win     = w_pick[2];
    assign w_win_idx = w_pick[1:0];

    always_comb begin
        case (w_win_idx)
            2'd0:    begin w_sel_addr = addr0; w_sel_din = din0; w_sel_we = we0; end
            2'd1:    begin w_sel_addr = addr1; w_sel_din = din1; w_sel_we = we1; end
            default: begin w_sel_addr = addr2; w_sel_din = din2; w_sel_we = we2; end
        endcase
    end

    always_comb begin
        w_state_nx    = r_state;
        w_grant_nx    = r_grant;
        w_ok_nx       = 3'b000;
        w_ram_addr_nx = r_ram_addr;
        w_ram_din_nx  = r_ram_din;
        w_ram_we_nx   = 1'b0;
        w_dout0_nx    = r_dout0;
        w_dout1_nx    = r_dout1;
        w_dout2_nx    = r_dout2;
`ifndef JTFRAME_RAM_ARB_FIXPRIO_EN
        w_last_nx     = r_last;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_win) begin
                    w_ram_addr_nx = w_sel_addr;
                    w_ram_din_nx  = w_sel_din;
                    w_ram_we_nx   = w_sel_we;
                    w_grant_nx    = w_win_idx;
`ifndef JTFRAME_RAM_ARB_FIXPRIO_EN
                    w_last_nx     = w_win_idx;
`endif
                    w_state_nx    = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // Writes complete here; reads need one more cycle for ram_q.
                if (r_ram_we) begin
                    case (r_grant)
                        2'd0:    w_ok_nx = 3'b001;
                        2'd1:    w_ok_nx = 3'b010;
                        default: w_ok_nx = 3'b100;
                    endcase
                    w_state_nx = S_IDLE;
                end else begin
                    w_state_nx = S_LATCH;
                end
            end
            S_LATCH: begin
                case (r_grant)
                    2'd0:    begin w_dout0_nx = ram_q; w_ok_nx = 3'b001; end
                    2'd1:    begin w_dout1_nx = ram_q; w_ok_nx = 3'b010; end
                    default: begin w_dout2_nx = ram_q; w_ok_nx = 3'b100; end
                endcase
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_grant    <= 2'd0;
            r_ok       <= 3'b000;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_ram_we   <= 1'b0;
            r_dout0    <= '0;
            r_dout1    <= '0;
            r_dout2    <= '0;
`ifndef JTFRAME_RAM_ARB_FIXPRIO_EN
            r_last     <= 2'd2;
`endif
        end else begin
            r_state    <= w_state_nx;
            r_grant    <= w_grant_nx;
            r_ok       <= w_ok_nx;
            r_ram_addr <= w_ram_addr_nx;
            r_ram_din  <= w_ram_din_nx;
            r_ram_we   <= w_ram_we_nx;
            r_dout0    <= w_dout0_nx;
            r_dout1    <= w_dout1_nx;
            r_dout2    <= w_dout2_nx;
`ifndef JTFRAME_RAM_ARB_FIXPRIO_EN
            r_last     <= w_last_nx;
`endif
        end
    end

    assign ok0      = r_ok[0];
    assign ok1      = r_ok[1];
    assign ok2      = r_ok[2];
    assign dout0    = r_dout0;
    assign dout1    = r_dout1;
    assign dout2    = r_dout2;
    assign ram_addr = r_ram_addr;
    assign ram_din  = r_ram_din;
    assign ram_we   = r_ram_we;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_jtframe_ram_arb.sv
// Directed bench for jtframe_ram_arb with a registered-read RAM model attached.
module tb_jtframe_ram_arb;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, req2, we0, we1, we2;
    logic [9:0] addr0, addr1, addr2;
    logic [7:0] din0, din1, din2, dout0, dout1, dout2;
    logic       ok0, ok1, ok2, busy, ram_we;
    logic [9:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_q = 8'h00;
    logic [7:0] mem [0:1023];
    int total = 0;
    int bad   = 0;

    jtframe_ram_arb #(.DW(8), .AW(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .req2(req2),
        .we0(we0), .we1(we1), .we2(we2),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .din0(din0), .din1(din1), .din2(din2),
        .dout0(dout0), .dout1(dout1), .dout2(dout2),
        .ok0(ok0), .ok1(ok1), .ok2(ok2), .busy(busy),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_q <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33;
        req0 = 0; req1 = 0; req2 = 0; we0 = 0; we1 = 0; we2 = 0;
        addr0 = '0; addr1 = '0; addr2 = '0; din0 = '0; din1 = '0; din2 = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_ok", 32'({ok2, ok1, ok0}), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_we", 32'(ram_we), 32'h0);
        chk("rst_addr", 32'(ram_addr), 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // single write then read on client 1
        req1 = 1; we1 = 1; addr1 = 10'h155; din1 = 8'hA5;
        tick();
        chk("wr_c1_we", 32'(ram_we), 32'h1);
        chk("wr_c1_addr", 32'(ram_addr), 32'h155);
        chk("wr_c1_din", 32'(ram_din), 32'hA5);
        chk("wr_c1_ok", 32'({ok2, ok1, ok0}), 32'h0);
        tick();
        chk("wr_c2_ok", 32'({ok2, ok1, ok0}), 32'h2);
        chk("wr_c2_we", 32'(ram_we), 32'h0);
        req1 = 0;
        tick();
        chk("wr_c3_ok", 32'({ok2, ok1, ok0}), 32'h0);
        req1 = 1; we1 = 0;
        tick();
        chk("rd_c1_busy", 32'(busy), 32'h1);
        chk("rd_c1_we", 32'(ram_we), 32'h0);
        tick();
        chk("rd_c2_ok", 32'({ok2, ok1, ok0}), 32'h0);
        tick();
        chk("rd_c3_ok", 32'({ok2, ok1, ok0}), 32'h2);
        chk("rd_c3_dout1", 32'(dout1), 32'hA5);
        req1 = 0;
        tick();

        // reset while a read of client 0 sits in LATCH
        req0 = 1; we0 = 0; addr0 = 10'h001;
        tick(); tick();
        chk("rr_latch_busy", 32'(busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        req0 = 0;
        chk("rr_ok", 32'({ok2, ok1, ok0}), 32'h0);
        chk("rr_we", 32'(ram_we), 32'h0);
        chk("rr_busy", 32'(busy), 32'h0);
        chk("rr_dout0", 32'(dout0), 32'h0);
        chk("rr_dout1", 32'(dout1), 32'h0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rr_post_ok", 32'({ok2, ok1, ok0}), 32'h0);
        end

        // contention: all three read at once
        req0 = 1; req1 = 1; req2 = 1; we0 = 0; we1 = 0; we2 = 0;
        addr0 = 10'h001; addr1 = 10'h002; addr2 = 10'h003;
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk("cont_ok", 32'({ok2, ok1, ok0}),
                (c == 3) ? 32'h1 : (c == 6) ? 32'h2 : (c == 9) ? 32'h4 : 32'h0);
            if (c == 3) begin chk("cont_dout0", 32'(dout0), 32'h11); req0 = 0; end
            if (c == 6) begin chk("cont_dout1", 32'(dout1), 32'h22); req1 = 0; end
            if (c == 9) begin chk("cont_dout2", 32'(dout2), 32'h33); req2 = 0; end
        end
        tick();

        // fairness: req0 and req2 held continuously
        req0 = 1; req2 = 1; addr0 = 10'h001; addr2 = 10'h003;
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk("fair_ok", 32'({ok2, ok1, ok0}),
                (c == 3 || c == 9) ? 32'h1 : (c == 6 || c == 12) ? 32'h4 : 32'h0);
            if (c == 6) chk("fair_dout2", 32'(dout2), 32'h33);
        end
        req0 = 0; req2 = 0;
        tick();
        chk("fair_idle", 32'(busy), 32'h0);

        // masking: req0 held through its ok cycle
        req0 = 1; we0 = 1; addr0 = 10'h010; din0 = 8'h5A;
        tick();
        chk("mask_we", 32'(ram_we), 32'h1);
        tick();
        chk("mask_ok", 32'({ok2, ok1, ok0}), 32'h1);
        tick();
        chk("mask_busy", 32'(busy), 32'h0);
        chk("mask_we2", 32'(ram_we), 32'h0);
        req0 = 0; we0 = 0;
        tick();
        chk("mask_busy2", 32'(busy), 32'h0);
        req2 = 1; we2 = 0; addr2 = 10'h010;
        tick(); tick(); tick();
        chk("mask_rb_ok", 32'({ok2, ok1, ok0}), 32'h4);
        chk("mask_rb_dout2", 32'(dout2), 32'h5A);
        req2 = 0;
        tick();

        // late req0 against waiting req2 after a grant to req1
        req1 = 1; req2 = 1; addr1 = 10'h002; addr2 = 10'h003; we1 = 0; we2 = 0;
        tick();
        req0 = 1; addr0 = 10'h001; we0 = 0;
        tick(); tick();
        chk("late_ok1", 32'({ok2, ok1, ok0}), 32'h2);
        req1 = 0;
        tick();
`ifdef JTFRAME_RAM_ARB_FIXPRIO_EN
        chk("late_addr", 32'(ram_addr), 32'h001);
        tick(); tick();
        chk("late_ok_win", 32'({ok2, ok1, ok0}), 32'h1);
        chk("late_dout0", 32'(dout0), 32'h11);
        req0 = 0;
        tick(); tick(); tick();
        chk("late_ok_next", 32'({ok2, ok1, ok0}), 32'h4);
        req2 = 0;
`else
        chk("late_addr", 32'(ram_addr), 32'h003);
        tick(); tick();
        chk("late_ok_win", 32'({ok2, ok1, ok0}), 32'h4);
        chk("late_dout2", 32'(dout2), 32'h33);
        req2 = 0;
        tick(); tick(); tick();
        chk("late_ok_next", 32'({ok2, ok1, ok0}), 32'h1);
        chk("late_dout0", 32'(dout0), 32'h11);
        req0 = 0;
`endif
        tick();
        chk("end_idle", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
